// File: rtl/tenkey_scan.sv
// 4x3 matrix keypad scanner with full-scan debounce.
// Emits level outputs for the lock core plus a press strobe and key code.
module tenkey_scan #(
  parameter int SCAN_DIV = 4,
  parameter int DEBOUNCE = 3
) (
  input  logic       ck,
  input  logic       reset,
  input  logic [2:0] col,
  output logic [3:0] row,
  output logic [9:0] tenkey,
  output logic       close,
  output logic       cancel,
  output logic       key_valid,
  output logic [3:0] key_code
);

  localparam int DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [DW-1:0] DIV_MAX = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DB_MAX  = CW'(DEBOUNCE);
  localparam logic [3:0]    NONE    = 4'hF;

  logic [DW-1:0] div_q, div_d;
  logic [1:0]    ridx_q, ridx_d;
  logic [3:0]    row_q, row_d;
  logic [3:0]    acc_q, acc_d;
  logic          multi_q, multi_d;
  logic [3:0]    prev_q, prev_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    code_q, code_d;
  logic [9:0]    tenkey_q, tenkey_d;
  logic          close_q, close_d;
  logic          cancel_q, cancel_d;
  logic          valid_q, valid_d;

  function automatic logic [3:0] key_at(
    input logic [1:0] r,
    input logic [1:0] c
  );
    logic [3:0] k;
    if (r != 2'd3) begin
      k = {2'b00, r} * 4'd3 + {2'b00, c} + 4'd1;
    end else begin
      unique case (c)
        2'd0:    k = 4'd10;
        2'd1:    k = 4'd0;
        default: k = 4'd11;
      endcase
    end
    return k;
  endfunction

  logic       sample;
  logic [1:0] ncol;
  logic [1:0] cidx;
  logic [3:0] code_n;
  logic       multi_n;
  logic [3:0] res;
  logic [CW-1:0] cnt_n;

  always_comb begin
    div_d    = div_q;
    ridx_d   = ridx_q;
    row_d    = row_q;
    acc_d    = acc_q;
    multi_d  = multi_q;
    prev_d   = prev_q;
    cnt_d    = cnt_q;
    code_d   = code_q;
    tenkey_d = tenkey_q;
    close_d  = close_q;
    cancel_d = cancel_q;
    valid_d  = 1'b0;
    res      = NONE;
    cnt_n    = cnt_q;

    sample = (div_q == DIV_MAX);
    ncol   = {1'b0, col[0]} + {1'b0, col[1]} + {1'b0, col[2]};
    if (col[0])      cidx = 2'd0;
    else if (col[1]) cidx = 2'd1;
    else             cidx = 2'd2;

    // Fold this row's hits into the running scan result.
    code_n  = acc_q;
    multi_n = multi_q;
    if (ncol > 2'd1) begin
      multi_n = 1'b1;
    end else if (ncol == 2'd1) begin
      if (acc_q != NONE) multi_n = 1'b1;
      else               code_n  = key_at(ridx_q, cidx);
    end

    if (sample) begin
      div_d  = '0;
      ridx_d = ridx_q + 2'd1;
      row_d  = 4'b0001 << ridx_d;
    end else begin
      div_d  = div_q + DW'(1);
    end

    if (sample && ridx_q != 2'd3) begin
      acc_d   = code_n;
      multi_d = multi_n;
    end

    if (sample && ridx_q == 2'd3) begin
      res     = multi_n ? NONE : code_n;
      acc_d   = NONE;
      multi_d = 1'b0;
      if (res == prev_q) begin
        cnt_n = (cnt_q == DB_MAX) ? cnt_q : cnt_q + CW'(1);
      end else begin
        cnt_n  = CW'(1);
        prev_d = res;
      end
      cnt_d = cnt_n;
      if (cnt_n == DB_MAX && res != code_q) begin
        code_d   = res;
        valid_d  = (res != NONE);
        tenkey_d = (res <= 4'd9) ? (10'd1 << res) : 10'd0;
        close_d  = (res == 4'd11);
        cancel_d = (res == 4'd10);
      end
    end
  end

  always_ff @(posedge ck or posedge reset) begin
    if (reset) begin
      div_q    <= '0;
      ridx_q   <= 2'd0;
      row_q    <= 4'b0001;
      acc_q    <= NONE;
      multi_q  <= 1'b0;
      prev_q   <= NONE;
      cnt_q    <= '0;
      code_q   <= NONE;
      tenkey_q <= '0;
      close_q  <= 1'b0;
      cancel_q <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      div_q    <= div_d;
      ridx_q   <= ridx_d;
      row_q    <= row_d;
      acc_q    <= acc_d;
      multi_q  <= multi_d;
      prev_q   <= prev_d;
      cnt_q    <= cnt_d;
      code_q   <= code_d;
      tenkey_q <= tenkey_d;
      close_q  <= close_d;
      cancel_q <= cancel_d;
      valid_q  <= valid_d;
    end
  end

  assign row       = row_q;
  assign tenkey    = tenkey_q;
  assign close     = close_q;
  assign cancel    = cancel_q;
  assign key_valid = valid_q;
  assign key_code  = code_q;

endmodule

// File: tb/tb_tenkey_scan.sv
// Bench for tenkey_scan: keypad model plus scan-level debounce reference.
module tb_tenkey_scan;

  localparam int SD = 2;
  localparam int DB = 3;
  localparam int SP = 4 * SD;

  logic       ck = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] col;
  logic [3:0] row;
  logic [9:0] tenkey;
  logic       close, cancel, key_valid;
  logic [3:0] key_code;
  logic [11:0] keys = '0;

  tenkey_scan #(.SCAN_DIV(SD), .DEBOUNCE(DB)) dut (
    .ck(ck), .reset(reset), .col(col), .row(row),
    .tenkey(tenkey), .close(close), .cancel(cancel),
    .key_valid(key_valid), .key_code(key_code)
  );

  always #5 ck = ~ck;

  // Keypad: a pressed key shorts its row line to its column line.
  always_comb begin
    col = '0;
    for (int r = 0; r < 4; r++)
      if (row[r])
        for (int j = 0; j < 3; j++)
          col[j] = col[j] | keys[r*3+j];
  end

  int code_tab[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 0, 11};
  int n_chk = 0;
  int n_pass = 0;
  int hist[$];
  int exp_code = 15;
  int got[$];

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic int scan_result(input logic [11:0] k);
    if ($countones(k) != 1) return 15;
    for (int i = 0; i < 12; i++) if (k[i]) return code_tab[i];
    return 15;
  endfunction

  function automatic int exp_tk(input int c);
    return (c <= 9) ? (1 << c) : 0;
  endfunction

  task automatic model_reset();
    hist.delete();
    exp_code = 15;
  endtask

  task automatic check_reset_vals();
    check("rst_row", int'(row), 1);
    check("rst_code", int'(key_code), 15);
    check("rst_tenkey", int'(tenkey), 0);
    check("rst_valid", int'(key_valid), 0);
    check("rst_close", int'(close), 0);
    check("rst_cancel", int'(cancel), 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    @(posedge ck); #1;
    check_reset_vals();
    @(negedge ck);
    reset = 1'b0;
  endtask

  task automatic run_scan(input logic [11:0] k);
    int r;
    bit commit;
    keys = k;
    r = scan_result(k);
    hist.push_back(r);
    if (hist.size() > DB) void'(hist.pop_front());
    commit = (hist.size() == DB);
    foreach (hist[i]) if (hist[i] != r) commit = 0;
    if (r == exp_code) commit = 0;
    for (int c = 1; c <= SP; c++) begin
      @(posedge ck); #1;
      check("row", int'(row), 1 << ((c / SD) % 4));
      if (c == SP && commit) exp_code = r;
      check("key_valid", int'(key_valid),
            int'(c == SP && commit && r != 15));
      check("key_code", int'(key_code), exp_code);
      if (key_valid) got.push_back(int'(key_code));
    end
    check("tenkey", int'(tenkey), exp_tk(exp_code));
    check("close", int'(close), int'(exp_code == 11));
    check("cancel", int'(cancel), int'(exp_code == 10));
  endtask

  task automatic hold(input logic [11:0] k, input int n);
    for (int i = 0; i < n; i++) run_scan(k);
  endtask

  function automatic logic [11:0] bit_of(input int b);
    return 12'(1) << b;
  endfunction

  int seq_bits[5] = '{0, 1, 2, 3, 11};
  int seq_codes[5] = '{1, 2, 3, 4, 11};

  initial begin
    do_reset();
    hold('0, 4);

    hold(bit_of(4), 6);
    hold('0, 4);

    hold(bit_of(0), 2);
    hold('0, 1);
    hold(bit_of(0), 3);
    hold('0, 4);

    hold(bit_of(11), 4);
    hold(bit_of(9), 4);
    hold('0, 4);
    hold(bit_of(3) | bit_of(6), 4);
    hold(bit_of(0) | bit_of(1), 4);
    hold('0, 3);

    got.delete();
    for (int i = 0; i < 5; i++) begin
      hold(bit_of(seq_bits[i]), 4);
      hold('0, 4);
    end
    check("seq_len", got.size(), 5);
    for (int i = 0; i < 5 && i < got.size(); i++)
      check("seq_code", got[i], seq_codes[i]);

    hold(bit_of(0), 4);
    hold(bit_of(1), 4);
    hold('0, 4);

    hold(bit_of(4), 4);
    hold(bit_of(8), 2);
    keys = bit_of(8);
    repeat (3) @(posedge ck);
    #1 reset = 1'b1;
    #1 check_reset_vals();
    model_reset();
    @(negedge ck);
    reset = 1'b0;
    hold(bit_of(8), 4);
    hold('0, 4);

    for (int s = 0; s < 40; s++) begin
      int sel;
      logic [11:0] k;
      sel = $urandom_range(0, 9);
      if (sel < 2)      k = '0;
      else if (sel < 8) k = bit_of($urandom_range(0, 11));
      else              k = bit_of($urandom_range(0, 11)) |
                            bit_of($urandom_range(0, 11));
      hold(k, $urandom_range(1, 5));
    end
    hold('0, 4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
